// File: rtl/operand_skew_loader.sv
// Skewed operand loader: streams one matrix operand per command into a
// 4x256 input memory with per-lane diagonal skew and zero padding.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_k command handshake, K (0 = terminator)
//   s_valid/s_ready/s_data    lane-major element stream
//   mem_we/mem_addr/mem_data  registered input-memory write port
//   instr_we/addr/data        instruction-memory write (slot, K)
//   busy, done, err           status: not idle, completion, overflow
module operand_skew_loader #(
  parameter int PAD        = 7,
  parameter bit EMIT_INSTR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_k,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_data,
  output logic        instr_we,
  output logic [2:0]  instr_addr,
  output logic [4:0]  instr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DISCARD,
    INSTR,
    FINISHED
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [8:0]  base;
  logic [2:0]  slot;
  logic [4:0]  k_r;
  logic [1:0]  lane;
  logic [5:0]  pos;
  logic [6:0]  cnt;
  logic        term;
  logic [5:0]  len;
  logic [5:0]  lane_w;
  logic [7:0]  col;
  logic        is_data;
  logic        last_pos;
  logic        is_term;
  logic        fits;
  logic        adv;

  assign len      = 6'(k_r) + 6'(PAD);
  assign lane_w   = 6'(lane);
  assign col      = base[7:0] + 8'(pos);
  assign last_pos = pos == len - 6'd1;
  assign is_term  = cmd_k == 5'd0;
  assign busy     = state != IDLE;

  // Lane i carries data in columns i .. i+K-1; the rest is skew/pad.
  assign is_data = (pos >= lane_w) &&
                   (pos < lane_w + 6'(k_r));

  // Slot 7 is kept for the terminator.
  assign fits = !is_term &&
                (10'(base) + 10'(cmd_k) + 10'(PAD)
                 <= 10'd256) &&
                slot != 3'd7;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    cmd_ready  = 1'b0;
    s_ready    = 1'b0;
    adv        = 1'b0;
    instr_we   = 1'b0;
    instr_addr = 3'd0;
    instr_data = 5'd0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (1'b1)
            is_term: state_n = INSTR;
            fits:    state_n = LOAD;
            default: state_n = DISCARD;
          endcase
        end
      end
      LOAD: begin
        // Zero positions never wait on the stream.
        s_ready = is_data;
        adv     = is_data ? s_valid : 1'b1;
        if (adv && lane == 2'd3 && last_pos)
          state_n = INSTR;
      end
      DISCARD: begin
        s_ready = 1'b1;
        if (s_valid && cnt == 7'd1)
          state_n = IDLE;
      end
      INSTR: begin
        instr_we   = EMIT_INSTR;
        instr_addr = slot;
        instr_data = term ? 5'd0 : k_r;
        done       = 1'b1;
        state_n    = term ? FINISHED : IDLE;
      end
      FINISHED: state_n = FINISHED;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= 9'd0;
      slot     <= 3'd0;
      k_r      <= 5'd0;
      lane     <= 2'd0;
      pos      <= 6'd0;
      cnt      <= 7'd0;
      term     <= 1'b0;
      err      <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 10'd0;
      mem_data <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            k_r  <= cmd_k;
            lane <= 2'd0;
            pos  <= 6'd0;
            term <= is_term;
            cnt  <= {cmd_k, 2'b00};
            if (!is_term && !fits)
              err <= 1'b1;
          end
        end
        LOAD: begin
          if (adv) begin
            mem_we   <= 1'b1;
            mem_addr <= {lane, col};
            mem_data <= is_data ? s_data : 16'd0;
            if (last_pos) begin
              pos  <= 6'd0;
              lane <= lane + 2'd1;
            end else begin
              pos <= pos + 6'd1;
            end
          end
        end
        DISCARD: begin
          if (s_valid)
            cnt <= cnt - 7'd1;
        end
        INSTR: begin
          slot <= slot + 3'd1;
          if (!term)
            base <= base + 9'(len);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_skew_loader.sv
// Self-checking bench for operand_skew_loader against a
// write-list reference model built from the skew rules.
module tb_operand_skew_loader;

  localparam int PAD = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_k;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        instr_we;
  logic [2:0]  instr_addr;
  logic [4:0]  instr_data;
  logic        busy;
  logic        done;
  logic        err;

  operand_skew_loader #(
    .PAD(PAD),
    .EMIT_INSTR(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_k(cmd_k),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .instr_we(instr_we),
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  logic [25:0] wq[$];
  logic [25:0] exq[$];
  logic [7:0]  iq[$];
  logic [15:0] elem_q[$];

  int   base_m;
  int   slot_m;
  logic err_m;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_data});
    if (instr_we) iq.push_back({instr_addr, instr_data});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_k     = 5'd0;
    s_valid   = 1'b0;
    s_data    = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    base_m = 0;
    slot_m = 0;
    err_m  = 1'b0;
  endtask

  task automatic fill_seq(input int start, input int n);
    elem_q.delete();
    for (int i = 0; i < n; i++)
      elem_q.push_back(16'(start + i));
  endtask

  task automatic fill_rand(input int n);
    elem_q.delete();
    for (int i = 0; i < n; i++)
      elem_q.push_back(16'($urandom));
  endtask

  // mode 0: s_valid always 1, 1: toggling, 2: random
  task automatic do_cmd(input int k, input int mode,
                        input string tag);
    int L;
    bit term;
    bit ok;
    bit exp_instr;
    int n;
    int idx;
    int t;
    int acc;
    bit fire;
    bit fin;
    logic [15:0] d;
    L    = k + PAD;
    term = (k == 0);
    ok   = !term && (base_m + L <= 256) && (slot_m < 7);
    exp_instr = term || ok;
    exq.delete();
    if (ok) begin
      for (int l = 0; l < 4; l++) begin
        for (int c = 0; c < L; c++) begin
          if (c >= l && c < l + k) d = elem_q[l*k + c - l];
          else d = 16'd0;
          exq.push_back({10'(l*256 + base_m + c), d});
        end
      end
    end
    wq.delete();
    iq.delete();
    done_cnt = 0;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_k     = 5'(k);
    #1;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    acc = cyc;
    @(posedge clk);

    n   = term ? 0 : 4 * k;
    idx = 0;
    t   = 0;
    while (idx < n && t < 4000) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (t % 2) == 1;
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = elem_q[idx];
      #1;
      fire = s_valid && s_ready;
      @(posedge clk);
      if (fire) idx++;
      t++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    s_valid   = 1'b0;
    chk({tag, "_elems"}, 32'(idx), 32'(n));

    t   = 0;
    fin = 1'b0;
    while (!fin && t < 400) begin
      if (exp_instr) fin = done_cnt > 0;
      else           fin = !busy;
      if (!fin) begin
        @(negedge clk);
        t++;
      end
    end
    chk({tag, "_complete"}, 32'(fin), 32'd1);
    @(negedge clk);

    chk({tag, "_nwrites"}, 32'(wq.size()),
        32'(exq.size()));
    for (int i = 0; i < wq.size() && i < exq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i),
          32'(wq[i]), 32'(exq[i]));
    chk({tag, "_ninstr"}, 32'(iq.size()),
        32'(exp_instr));
    if (exp_instr && iq.size() > 0)
      chk({tag, "_instr"}, 32'(iq[0]),
          32'({3'(slot_m), term ? 5'd0 : 5'(k)}));
    chk({tag, "_done"}, 32'(done_cnt), 32'(exp_instr));
    if (!ok && !term) err_m = 1'b1;
    chk({tag, "_err"}, 32'(err), 32'(err_m));
    if (mode == 0 && ok)
      chk({tag, "_latency"}, 32'(done_cyc - acc),
          32'(4 * L + 1));

    if (ok) base_m += L;
    if (exp_instr) slot_m++;
  endtask

  initial begin
    int bad;
    int kr;
    do_reset();

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_instr_we", 32'(instr_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    fill_seq(1, 8);
    do_cmd(2, 0, "k2");
    fill_seq(10, 12);
    do_cmd(3, 0, "k3");
    do_cmd(0, 0, "term2");

    cmd_valid = 1'b1;
    cmd_k     = 5'd3;
    s_valid   = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready || s_ready || mem_we || !busy)
        bad++;
    end
    cmd_valid = 1'b0;
    s_valid   = 1'b0;
    chk("finished_hold", 32'(bad), 32'd0);

    do_reset();
    fill_seq(1, 8);
    do_cmd(2, 1, "k2_toggle");
    for (int r = 0; r < 3; r++) begin
      kr = $urandom_range(1, 20);
      fill_rand(4 * kr);
      do_cmd(kr, 2, $sformatf("rand%0d", r));
    end

    do_reset();
    for (int r = 0; r < 6; r++) begin
      fill_rand(124);
      do_cmd(31, 0, $sformatf("k31_%0d", r));
    end
    fill_rand(124);
    do_cmd(31, 2, "ovf");
    fill_rand(84);
    do_cmd(21, 0, "edge256");
    if (wq.size() > 0)
      chk("edge_last_addr", 32'(wq[wq.size()-1][25:16]),
          32'd1023);
    do_cmd(0, 0, "term7");

    do_reset();
    for (int r = 0; r < 6; r++) begin
      fill_rand(124);
      do_cmd(31, 0, $sformatf("b31_%0d", r));
    end
    fill_rand(124);
    do_cmd(31, 2, "ovf2");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_k     = 5'd4;
    #1;
    chk("abort_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      s_valid   = 1'b1;
      s_data    = 16'(100 + i);
    end
    @(negedge clk);
    chk("abort_pre_we", 32'(mem_we), 32'd1);
    rst     = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    rst    = 1'b0;
    base_m = 0;
    slot_m = 0;
    err_m  = 1'b0;
    fill_seq(40, 4);
    do_cmd(1, 0, "after_abort");
    if (wq.size() > 0)
      chk("after_abort_first", 32'(wq[0]),
          32'({10'd0, 16'd40}));

    do_reset();
    for (int r = 0; r < 7; r++) begin
      fill_rand(4);
      do_cmd(1, 2, $sformatf("slot%0d", r));
    end
    fill_rand(4);
    do_cmd(1, 2, "slot7_rej");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
